// File: rtl/uart_boot_loader.sv
// UART (8N1) boot loader: receives a length-prefixed image and writes it into SRAM
// over the PicoRV32 native memory interface, holding the CPU in reset until complete.
module uart_boot_loader #(
    parameter int unsigned CLK_DIV   = 868,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 8192
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        cpu_resetn,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLK_DIV - 1);
    localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [2:0] {LD_LEN, LD_DATA, LD_WRITE, LD_DONE, LD_ERROR} ld_state_e;

    rx_state_e        rx_state_q;
    logic [1:0]       rx_sync_q;
    logic             rx_prev_q;
    logic [CNT_W-1:0] rx_cnt_q;
    logic [2:0]       rx_bit_q;
    logic [7:0]       rx_shift_q;
    logic             rx_valid_q;
    logic             rx_ferr_q;
    logic             rx_start_q;

    ld_state_e        ld_state_q;
    logic [31:0]      len_q;
    logic [31:0]      idx_q;
    logic [31:0]      word_q;
    logic [1:0]       bcnt_q;
    logic             mem_valid_q;
    logic [31:0]      mem_addr_q;
    logic [31:0]      mem_wdata_q;
    logic [3:0]       mem_wstrb_q;
    logic             cpu_resetn_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic             rx_line_c;
    logic [31:0]      rx_word_c;

    assign rx_line_c = rx_sync_q[1];
    assign rx_word_c = {rx_shift_q, word_q[31:8]};

    // Receiver: start-bit qualification at mid-bit, then 8 data bits and a stop bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_start_q <= 1'b0;
        end else begin
            rx_sync_q  <= {rx_sync_q[0], uart_rx};
            rx_prev_q  <= rx_line_c;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_start_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_line_c) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= HALF_M1;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == '0) begin
                        if (rx_line_c) begin
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_state_q <= RX_DATA;
                            rx_cnt_q   <= FULL_M1;
                            rx_bit_q   <= '0;
                            rx_start_q <= 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == '0) begin
                        rx_shift_q <= {rx_line_c, rx_shift_q[7:1]};
                        rx_cnt_q   <= FULL_M1;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == '0) begin
                        rx_state_q <= RX_IDLE;
                        rx_valid_q <= rx_line_c;
                        rx_ferr_q  <= !rx_line_c;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 1'b1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // Loader: length word, then data words each followed by one SRAM write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ld_state_q   <= LD_LEN;
            len_q        <= '0;
            idx_q        <= '0;
            word_q       <= '0;
            bcnt_q       <= '0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= BASE_ADDR;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= 4'b0000;
            cpu_resetn_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (rx_start_q && (ld_state_q != LD_DONE) && (ld_state_q != LD_ERROR)) begin
                busy_q <= 1'b1;
            end
            case (ld_state_q)
                LD_LEN, LD_DATA: begin
                    if (rx_ferr_q) begin
                        ld_state_q <= LD_ERROR;
                        err_q      <= 1'b1;
                        busy_q     <= 1'b0;
                    end else if (rx_valid_q) begin
                        word_q <= rx_word_c;
                        bcnt_q <= bcnt_q + 1'b1;
                        if (bcnt_q == 2'd3) begin
                            if (ld_state_q == LD_LEN) begin
                                len_q <= rx_word_c;
                                idx_q <= '0;
                                if (rx_word_c == '0) begin
                                    ld_state_q   <= LD_DONE;
                                    done_q       <= 1'b1;
                                    cpu_resetn_q <= 1'b1;
                                    busy_q       <= 1'b0;
                                end else if (rx_word_c > MAX_N) begin
                                    ld_state_q <= LD_ERROR;
                                    err_q      <= 1'b1;
                                    busy_q     <= 1'b0;
                                end else begin
                                    ld_state_q <= LD_DATA;
                                end
                            end else begin
                                ld_state_q  <= LD_WRITE;
                                mem_valid_q <= 1'b1;
                                mem_wstrb_q <= 4'b1111;
                                mem_wdata_q <= rx_word_c;
                                mem_addr_q  <= BASE_ADDR + {idx_q[29:0], 2'b00};
                            end
                        end
                    end
                end
                LD_WRITE: begin
                    // Any byte completing while a write is pending has nowhere to go
                    if (rx_ferr_q || rx_valid_q) begin
                        ld_state_q  <= LD_ERROR;
                        err_q       <= 1'b1;
                        busy_q      <= 1'b0;
                        mem_valid_q <= 1'b0;
                        mem_wstrb_q <= 4'b0000;
                    end else if (mem_ready) begin
                        mem_valid_q <= 1'b0;
                        mem_wstrb_q <= 4'b0000;
                        if (idx_q + 32'd1 == len_q) begin
                            ld_state_q   <= LD_DONE;
                            done_q       <= 1'b1;
                            cpu_resetn_q <= 1'b1;
                            busy_q       <= 1'b0;
                        end else begin
                            idx_q      <= idx_q + 32'd1;
                            ld_state_q <= LD_DATA;
                        end
                    end
                end
                LD_DONE: begin
                    busy_q <= 1'b0;
                end
                LD_ERROR: begin
                    busy_q      <= 1'b0;
                    mem_valid_q <= 1'b0;
                    mem_wstrb_q <= 4'b0000;
                end
                default: ld_state_q <= LD_ERROR;
            endcase
        end
    end

    assign mem_valid  = mem_valid_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign cpu_resetn = cpu_resetn_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: serial image stimulus, SRAM model with
// configurable ready latency, and a write scoreboard checked at each handshake.
module tb_uart_boot_loader;

    localparam int unsigned CLK_DIV   = 16;
    localparam logic [31:0] BASE      = 32'h0000_1000;
    localparam int unsigned MAX_WORDS = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        cpu_resetn;
    logic        busy;
    logic        done;
    logic        err;

    int          n_checks = 0;
    int          n_fail = 0;
    int          writes = 0;
    int          valid_cycles = 0;
    int unsigned lat = 0;
    int unsigned wait_cnt = 0;
    bit          held = 1'b0;
    logic [31:0] held_addr;
    logic [31:0] held_data;
    wr_t         sb[$];
    logic [31:0] sram[logic [31:0]];

    uart_boot_loader #(
        .CLK_DIV  (CLK_DIV),
        .BASE_ADDR(BASE),
        .MAX_WORDS(MAX_WORDS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rx   (uart_rx),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .cpu_resetn(cpu_resetn),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // SRAM model: ready follows valid after lat wait cycles
    always @(posedge clk) begin
        if (mem_valid && !mem_ready) wait_cnt <= wait_cnt + 1;
        else                         wait_cnt <= 0;
    end
    assign mem_ready = mem_valid && (wait_cnt >= lat);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: request stability while waiting, scoreboard compare on handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_valid) begin
                valid_cycles++;
                if (held) begin
                    check("hold_addr", mem_addr, held_addr);
                    check("hold_data", mem_wdata, held_data);
                end else begin
                    held      = 1'b1;
                    held_addr = mem_addr;
                    held_data = mem_wdata;
                end
            end
            if (mem_valid && mem_ready) begin
                wr_t e;
                writes++;
                held = 1'b0;
                check("wr_wstrb", 32'(mem_wstrb), 32'hF);
                check("wr_cpu_held", 32'(cpu_resetn), 32'd0);
                n_checks++;
                assert (sb.size() != 0) else begin
                    n_fail++;
                    $error("FAIL wr_expected: observed write addr 0x%0h expected no write", mem_addr);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("wr_addr", mem_addr, e.addr);
                    check("wr_data", mem_wdata, e.data);
                end
                sram[mem_addr] = mem_wdata;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        uart_rx = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        uart_rx = !bad_stop;
        repeat (CLK_DIV) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b0);
    endtask

    task automatic load_word(input int idx, input logic [31:0] w);
        wr_t e;
        e.addr = BASE + 32'(4 * idx);
        e.data = w;
        sb.push_back(e);
        send_word(w);
    endtask

    task automatic check_reset_vals();
        check("rst_valid", 32'(mem_valid), 32'd0);
        check("rst_addr", mem_addr, BASE);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_cpu", 32'(cpu_resetn), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        uart_rx = 1'b1;
        @(negedge clk);
        check_reset_vals();
        sb.delete();
        sram.delete();
        writes = 0;
        valid_cycles = 0;
        held = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_end(input string tag, input int bound);
        int n = 0;
        while (!(done || err) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(done || err), 32'd1);
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        do_reset();

        // Two-word image with wait states on the SRAM
        lat = 2;
        send_byte(8'h02, 1'b0);
        check("t1_busy", 32'(busy), 32'd1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        load_word(0, 32'hDEAD_BEEF);
        load_word(1, 32'h1234_5678);
        wait_end("t1_end", 200);
        check("t1_done", 32'(done), 32'd1);
        check("t1_cpu", 32'(cpu_resetn), 32'd1);
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_err", 32'(err), 32'd0);
        check("t1_writes", 32'(writes), 32'd2);
        check("t1_rb0", sram[BASE], 32'hDEAD_BEEF);
        check("t1_rb1", sram[BASE + 32'd4], 32'h1234_5678);
        send_byte(8'hA5, 1'b0);
        check("t1_ignore_done", 32'(done), 32'd1);
        check("t1_ignore_wr", 32'(writes), 32'd2);
        lat = 0;

        // Zero-length image
        do_reset();
        send_word(32'd0);
        wait_end("t2_end", 200);
        check("t2_done", 32'(done), 32'd1);
        check("t2_cpu", 32'(cpu_resetn), 32'd1);
        check("t2_valid", 32'(valid_cycles), 32'd0);

        // Length one past the limit
        do_reset();
        send_word(32'(MAX_WORDS + 1));
        repeat (4) @(negedge clk);
        check("t3_err", 32'(err), 32'd1);
        check("t3_cpu", 32'(cpu_resetn), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_valid", 32'(valid_cycles), 32'd0);

        // Length exactly at the limit fills through the last address
        do_reset();
        send_word(32'(MAX_WORDS));
        for (int i = 0; i < int'(MAX_WORDS); i++) load_word(i, 32'hC0DE_0000 + 32'(i * 32'h0101));
        wait_end("tmax_end", 200);
        check("tmax_done", 32'(done), 32'd1);
        check("tmax_writes", 32'(writes), 32'(MAX_WORDS));
        check("tmax_last", sram[BASE + 32'(4 * (MAX_WORDS - 1))], 32'hC0DE_0000 + 32'((MAX_WORDS - 1) * 32'h0101));

        // Framing error on the third data byte
        do_reset();
        send_word(32'd2);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        repeat (4) @(negedge clk);
        check("t4_err", 32'(err), 32'd1);
        check("t4_cpu", 32'(cpu_resetn), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        send_byte(8'h44, 1'b0);
        send_word(32'h5566_7788);
        check("t4_err_sticky", 32'(err), 32'd1);
        check("t4_done", 32'(done), 32'd0);
        check("t4_valid", 32'(valid_cycles), 32'd0);

        // Short low glitch while idle, then a one-word image
        do_reset();
        uart_rx = 1'b0;
        repeat (CLK_DIV / 4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * CLK_DIV) @(negedge clk);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_err", 32'(err), 32'd0);
        send_word(32'd1);
        load_word(0, 32'hA5C3_0F96);
        wait_end("t5_end", 200);
        check("t5_done", 32'(done), 32'd1);
        check("t5_writes", 32'(writes), 32'd1);
        check("t5_rb", sram[BASE], 32'hA5C3_0F96);

        // Reset after the first word of three, then full re-send
        do_reset();
        send_word(32'd3);
        load_word(0, 32'h0BAD_F00D);
        repeat (4) @(negedge clk);
        check("t6_first_wr", 32'(writes), 32'd1);
        do_reset();
        send_word(32'd3);
        load_word(0, 32'h1111_AAAA);
        load_word(1, 32'h2222_BBBB);
        load_word(2, 32'h3333_CCCC);
        wait_end("t6_end", 200);
        check("t6_done", 32'(done), 32'd1);
        check("t6_cpu", 32'(cpu_resetn), 32'd1);
        check("t6_writes", 32'(writes), 32'd3);
        check("t6_sb_empty", 32'(sb.size()), 32'd0);
        check("t6_rb2", sram[BASE + 32'd8], 32'h3333_CCCC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
